// File: rtl/addersub_pkg.sv
// addersub_pkg: op encodings and op-bit positions for the
// carry-segmented add/sub/compare pipeline.
package addersub_pkg;

  localparam int OP_W = 3;

  localparam int OP_ADDSUB  = 0;
  localparam int OP_SIGNEXT = 1;
  localparam int OP_IS_SLT  = 2;

  localparam logic [OP_W-1:0] OP_SUBU = 3'd0;
  localparam logic [OP_W-1:0] OP_ADDU = 3'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd2;
  localparam logic [OP_W-1:0] OP_ADD  = 3'd3;
  localparam logic [OP_W-1:0] OP_SLTU = 3'd4;
  localparam logic [OP_W-1:0] OP_SLT  = 3'd6;

  function automatic int seg_width(input int width, input int segs);
    return width / segs;
  endfunction

endpackage

// File: rtl/addersub_seg.sv
// addersub_seg: one combinational chunk of the segmented adder.
// The pipeline instantiates one per stage.
module addersub_seg #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // plain ripple add of one chunk with carry in/out
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

endmodule

// File: rtl/addersub_pipe.sv
// addersub_pipe: WIDTH+1 bit add/sub split into SEGS carry
// segments, one segment per pipeline stage, valid/ready flow.
module addersub_pipe
  import addersub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEGS  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_slt,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = seg_width(WIDTH, SEGS);
  localparam int XW = WIDTH + 1;

  logic          en;
  logic          ext_sx;
  logic          ext_add;
  logic [XW-1:0] ext_a;
  logic [XW-1:0] ext_b;

  logic          vld_p [SEGS];
  logic          sx_p  [SEGS];
  logic          cy_p  [SEGS];
  logic          ovf_p [SEGS];
  logic [XW-1:0] a_p   [SEGS];
  logic [XW-1:0] b_p   [SEGS];
  logic [XW-1:0] s_p   [SEGS];

  assign en       = ~(out_valid & ~out_ready);
  assign in_ready = en;

  // extend operands one bit and invert B for subtraction
  always_comb begin
    ext_sx  = op[OP_SIGNEXT];
    ext_add = op[OP_ADDSUB];
    ext_a   = {ext_sx & opA[WIDTH-1], opA};
    ext_b   = {ext_sx & opB[WIDTH-1], opB};
    if (!ext_add) begin
      ext_b = ~ext_b;
    end
  end

  for (genvar k = 0; k < SEGS; k++) begin : g_stg
    localparam int SW = (k == SEGS - 1) ? CW + 1 : CW;
    localparam int LO = k * CW;

    logic          v_i;
    logic          x_i;
    logic          c_i;
    logic [XW-1:0] a_i;
    logic [XW-1:0] b_i;
    logic [XW-1:0] s_i;
    logic [SW-1:0] seg_s;
    logic          seg_c;

    logic          vld_d, vld_q;
    logic          sx_d, sx_q;
    logic          cy_d, cy_q;
    logic          ovf_d, ovf_q;
    logic [XW-1:0] a_d, a_q;
    logic [XW-1:0] b_d, b_q;
    logic [XW-1:0] s_d, s_q;

    if (k == 0) begin : g_head
      assign v_i = in_valid;
      assign x_i = ext_sx;
      assign c_i = ~ext_add;
      assign a_i = ext_a;
      assign b_i = ext_b;
      assign s_i = '0;
    end else begin : g_body
      assign v_i = vld_p[k-1];
      assign x_i = sx_p[k-1];
      assign c_i = cy_p[k-1];
      assign a_i = a_p[k-1];
      assign b_i = b_p[k-1];
      assign s_i = s_p[k-1];
    end

    addersub_seg #(
      .W(SW)
    ) u_seg (
      .a   (a_i[SW-1:0]),
      .b   (b_i[SW-1:0]),
      .cin (c_i),
      .sum (seg_s),
      .cout(seg_c)
    );

    // drop chunk k into place, shift remaining operand chunks down
    always_comb begin
      vld_d          = v_i;
      sx_d           = x_i;
      cy_d           = seg_c;
      a_d            = a_i >> CW;
      b_d            = b_i >> CW;
      s_d            = s_i;
      s_d[LO +: SW]  = seg_s;
      ovf_d          = x_i & (s_d[WIDTH] ^ s_d[WIDTH-1]);
    end

    // stage register, frozen as a whole while the output stalls
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q <= 1'b0;
        sx_q  <= 1'b0;
        cy_q  <= 1'b0;
        ovf_q <= 1'b0;
        a_q   <= '0;
        b_q   <= '0;
        s_q   <= '0;
      end else if (en) begin
        vld_q <= vld_d;
        sx_q  <= sx_d;
        cy_q  <= cy_d;
        ovf_q <= ovf_d;
        a_q   <= a_d;
        b_q   <= b_d;
        s_q   <= s_d;
      end
    end

    assign vld_p[k] = vld_q;
    assign sx_p[k]  = sx_q;
    assign cy_p[k]  = cy_q;
    assign ovf_p[k] = ovf_q;
    assign a_p[k]   = a_q;
    assign b_p[k]   = b_q;
    assign s_p[k]   = s_q;
  end

  assign out_valid  = vld_p[SEGS-1];
  assign result     = s_p[SEGS-1][WIDTH-1:0];
  assign result_slt = s_p[SEGS-1][WIDTH];
  assign carry_out  = s_p[SEGS-1][WIDTH];
  assign overflow   = ovf_p[SEGS-1];

endmodule

// File: tb/tb_addersub_pipe.sv
// tb_addersub_pipe: directed checks on a 32/2 pipe plus random
// traffic on several WIDTH/SEGS builds against an integer model.
module tb_addersub_pipe;
  import addersub_pkg::*;

  localparam int NOPS  = 10000;
  localparam int BOUND = 60000;
  localparam int NCFG  = 5;

  logic clk = 1'b0;
  logic rst;
  logic go;
  bit   done [NCFG];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // true integer add/sub, folded to WIDTH+1 bits; ovf at bit 40
  function automatic logic [63:0] model(input int w,
      input logic [31:0] a, input logic [31:0] b,
      input logic [2:0] o);
    longint va, vb, v, half;
    logic [63:0] r;
    va   = longint'({32'b0, a});
    vb   = longint'({32'b0, b});
    half = longint'(1) << (w - 1);
    if (o[1] && a[w-1]) va = va - (half << 1);
    if (o[1] && b[w-1]) vb = vb - (half << 1);
    v = o[0] ? va + vb : va - vb;
    r = 64'(v) & ((64'd1 << (w + 1)) - 64'd1);
    r[40] = o[1] && (v < -half || v >= half);
    return r;
  endfunction

  logic        m_iv, m_ir, m_ov, m_ordy;
  logic [31:0] m_a, m_b, m_res;
  logic [2:0]  m_op;
  logic        m_slt, m_cy, m_ovf;

  addersub_pipe #(.WIDTH(32), .SEGS(2)) u_dut (
    .clk       (clk),
    .reset     (rst),
    .in_valid  (m_iv),
    .in_ready  (m_ir),
    .opA       (m_a),
    .opB       (m_b),
    .op        (m_op),
    .out_valid (m_ov),
    .out_ready (m_ordy),
    .result    (m_res),
    .result_slt(m_slt),
    .carry_out (m_cy),
    .overflow  (m_ovf)
  );

  task automatic send(input string tag, input logic [2:0] o,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] er, input logic eslt, input logic eovf);
    @(negedge clk);
    m_iv = 1'b1; m_op = o; m_a = a; m_b = b; m_ordy = 1'b1;
    @(negedge clk);
    m_iv = 1'b0;
    chk({tag, "_lat1"}, 64'(m_ov), 64'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 64'(m_ov), 64'd1);
    chk({tag, "_res"}, 64'(m_res), 64'(er));
    chk({tag, "_slt"}, 64'(m_slt), 64'(eslt));
    chk({tag, "_cy"}, 64'(m_cy), 64'(eslt));
    chk({tag, "_ovf"}, 64'(m_ovf), 64'(eovf));
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_rnd
    localparam int W = (g < 3) ? 32 : 8;
    localparam int S = (g == 0) ? 1 : (g == 1) ? 2 :
                       (g == 2) ? 4 : (g == 3) ? 8 : 2;

    logic         iv, ir, ov, ordy, r_slt, r_cy, r_ovf;
    logic [W-1:0] a, b, res;
    logic [2:0]   o;

    addersub_pipe #(.WIDTH(W), .SEGS(S)) u_dut (
      .clk       (clk),
      .reset     (rst),
      .in_valid  (iv),
      .in_ready  (ir),
      .opA       (a),
      .opB       (b),
      .op        (o),
      .out_valid (ov),
      .out_ready (ordy),
      .result    (res),
      .result_slt(r_slt),
      .carry_out (r_cy),
      .overflow  (r_ovf)
    );

    function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      v = W'($urandom);
      case ($urandom_range(0, 7))
        0: v = '1;
        1: v = '0;
        2: v = {1'b1, {(W-1){1'b0}}};
        3: v = {1'b0, {(W-1){1'b1}}};
        default: ;
      endcase
      return v;
    endfunction

    initial begin
      logic [63:0] q [$];
      logic [63:0] e, gv;
      int sent, cyc;
      iv = 1'b0; a = '0; b = '0; o = '0; ordy = 1'b1;
      sent = 0; cyc = 0;
      wait (go);
      while ((sent < NOPS || q.size() > 0) && cyc < BOUND) begin
        @(negedge clk);
        iv   = (sent < NOPS) && ($urandom_range(0, 3) != 0);
        a    = pick();
        b    = pick();
        o    = 3'($urandom_range(0, 7));
        ordy = ($urandom_range(0, 3) != 0);
        #1;
        if (ov && ordy) begin
          if (q.size() == 0) begin
            chk($sformatf("rnd%0d_spurious", g), 64'(ov), 64'd0);
          end else begin
            e  = q.pop_front();
            gv = 64'(res) | (64'(r_slt) << W) | (64'(r_ovf) << 40);
            chk($sformatf("rnd%0d_out", g), gv, e);
            chk($sformatf("rnd%0d_cy", g), 64'(r_cy), 64'(e[W]));
          end
        end
        if (iv && ir) begin
          q.push_back(model(W, 32'(a), 32'(b), o));
          sent++;
        end
        cyc++;
      end
      iv = 1'b0;
      chk($sformatf("rnd%0d_drain", g),
          64'(q.size() + (NOPS - sent)), 64'd0);
      done[g] = 1'b1;
    end
  end

  initial begin
    logic [63:0] sq [$];
    logic [63:0] gv;
    int sent, got;
    logic all_done;
    rst = 1'b1; go = 1'b0;
    m_iv = 1'b0; m_a = '0; m_b = '0; m_op = '0; m_ordy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ovld", 64'(m_ov), 64'd0);
    chk("rst_rdy", 64'(m_ir), 64'd1);
    chk("rst_res", 64'(m_res), 64'd0);
    chk("rst_flags", 64'({m_slt, m_cy, m_ovf}), 64'd0);
    rst = 1'b0;

    send("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1);
    send("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 1, 0);
    send("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 0, 0);
    send("subu", OP_SUBU, 32'h5, 32'h7, 32'hFFFF_FFFE, 1, 0);
    send("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1, 1);
    send("op7", 3'd7, 32'h8000_0000, 32'h8000_0000, 32'h0, 1, 1);
    send("op5", 3'd5, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0);

    sent = 0; got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      m_iv   = (sent < 8);
      m_op   = 3'(sent);
      m_a    = $urandom;
      m_b    = $urandom;
      m_ordy = !(c >= 3 && c <= 5);
      #1;
      chk("stall_rdy", 64'(m_ir), 64'(!(c >= 3 && c <= 5)));
      if (m_ov) begin
        if (sq.size() == 0) begin
          chk("stall_spurious", 64'(m_ov), 64'd0);
        end else begin
          gv = 64'(m_res) | (64'(m_slt) << 32) | (64'(m_ovf) << 40);
          chk("stall_out", gv, sq[0]);
          if (m_ordy) begin
            void'(sq.pop_front());
            got++;
          end
        end
      end
      if (m_iv && m_ir) begin
        sq.push_back(model(32, m_a, m_b, m_op));
        sent++;
      end
    end
    m_iv = 1'b0;
    chk("stall_cnt", 64'(got), 64'd8);

    @(negedge clk);
    m_iv = 1'b1; m_op = OP_ADD; m_a = 32'h1234; m_b = 32'h4321;
    @(negedge clk);
    m_op = OP_SUB; m_a = 32'h99; m_b = 32'h11;
    @(negedge clk);
    m_iv = 1'b0;
    rst  = 1'b1;
    #1;
    chk("mid_rst_ovld", 64'(m_ov), 64'd0);
    chk("mid_rst_res", 64'(m_res), 64'd0);
    chk("mid_rst_rdy", 64'(m_ir), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_ovld", 64'(m_ov), 64'd0);
    end
    send("after_rst", OP_ADD, 32'h1, 32'h2, 32'h3, 0, 0);

    go = 1'b1;
    all_done = 1'b0;
    for (int c = 0; c < BOUND + 10000 && !all_done; c++) begin
      @(negedge clk);
      all_done = done[0] && done[1] && done[2] && done[3] && done[4];
    end
    chk("rnd_done", 64'(all_done), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/addersub_pipe.md
ADDERSUB_PIPE -- requirements
Module: addersub_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter SEGS, default 2, number of carry segments and pipeline stages; WIDTH mod SEGS SHALL be 0 and SEGS SHALL be 1 to 8.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand/op presented this cycle.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 opA  input  WIDTH  first operand.
REQ-008 opB  input  WIDTH  second operand.
REQ-009 op  input  3  op[2]=is_slt, op[1]=signext, op[0]=addsub (0 SUBU, 1 ADDU, 2 SUB, 3 ADD, 4 SLTU, 6 SLT).
REQ-010 out_valid  output  1  result fields valid.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 result  output  WIDTH  low WIDTH bits of extended sum.
REQ-013 result_slt  output  1  bit WIDTH of extended sum (less-than flag for ops 4/6).
REQ-014 carry_out  output  1  identical to result_slt; unsigned carry/borrow for ops 0/1.
REQ-015 overflow  output  1  signed overflow flag.

Function
REQ-016 Arithmetic SHALL be WIDTH+1 bits: operands extended by signext&msb; addsub=1 gives oA+oB, addsub=0 gives oA+~oB+1.
REQ-017 Op codes 5 and 7 SHALL be decoded bitwise per REQ-016 with no error.
REQ-018 Sum SHALL be split into SEGS chunks of WIDTH/SEGS bits; top chunk additionally carries bit WIDTH.
REQ-019 Stage k (0..SEGS-1) SHALL compute chunk k using the carry registered by stage k-1 (stage 0 carry-in = ~addsub); higher chunks' operands and lower chunks' results SHALL be skew-registered alongside.
REQ-020 Latency SHALL be exactly SEGS cycles from accepted input (in_valid&in_ready) to out_valid with no stall; throughput one op per cycle.
REQ-021 overflow SHALL be sum[WIDTH]^sum[WIDTH-1] when signext=1, else 0.
REQ-022 Pipeline enable SHALL be en = ~(out_valid & ~out_ready); in_ready SHALL equal en.
REQ-023 When en=0 every stage register including valids SHALL hold; outputs SHALL stay stable until out_ready.
REQ-024 A valid bit SHALL travel with each stage; bubbles (in_valid=0) SHALL propagate as out_valid=0.
REQ-025 Simultaneous accept and output handshake in one cycle SHALL advance the whole pipe with no loss or duplication.
REQ-026 SEGS=1 SHALL degenerate to one registered full-width add with latency 1.
REQ-027 Output fields SHALL be registered outputs of the last stage; no combinational input-to-output path except in_ready from out_ready/out_valid.

Reset
REQ-028 reset=1 SHALL immediately clear all stage valids, out_valid, result, result_slt, carry_out, overflow and all carry registers to 0.
REQ-029 Reset mid-operation SHALL discard all in-flight ops; first input after reset release SHALL emerge after SEGS cycles.
REQ-030 in_ready SHALL be 1 during and after reset (out_valid=0).

Structure
REQ-031 Shared package addersub_pkg SHALL hold op encoding constants (OP_SUBU, OP_ADDU, OP_SUB, OP_ADD, OP_SLTU, OP_SLT) and op bit-index constants.
REQ-032 One sub-module addersub_seg SHALL implement a combinational chunk adder (a, b, cin -> sum, cout), parametrised by chunk width, instantiated SEGS times via generate.

Verification
REQ-033 WIDTH=32,SEGS=2: op=3, opA=0x7FFFFFFF, opB=1 -> after 2 cycles result=0x80000000, overflow=1, carry_out=0.
REQ-034 op=6, opA=0xFFFFFFFF, opB=1 -> result_slt=1; same operands op=4 -> result_slt=0, result=0xFFFFFFFE.
REQ-035 op=0, opA=5, opB=7 -> result=0xFFFFFFFE, carry_out=1, overflow=0.
REQ-036 Back-to-back 8 ops, out_ready low cycles 3-5 -> in_ready low those cycles, outputs held, all 8 results in order, none lost.
REQ-037 Assert reset with 2 ops in flight -> out_valid=0 at once; no stale output after release; next op correct after 2 cycles.
REQ-038 Random 10k ops for SEGS in {1,2,4,8}, WIDTH in {8,32}, vs behavioural (WIDTH+1)-bit model -> zero mismatches.
